// File: rtl/code_entry_unit.sv
`default_nettype none
// ============================================================================
// Module      : code_entry_unit
// Description : Keypad front end for the access controller. Collects hex digit
//               strobes into an 8-bit code (first digit in the MSBs) and drives
//               the controller's request / confirm / user inputs. Handles
//               session start, cancel, enter and an optional inactivity timeout.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clock        in   1        system clock, rising edge
//   reset        in   1        asynchronous, active-high; clears all state
//   start_btn    in   1        pulse, opens a session (IDLE only)
//   cancel_btn   in   1        pulse, aborts the session
//   key_valid    in   1        strobe, key_code valid
//   key_code     in   DIGIT_W  digit value
//   enter_btn    in   1        pulse, submit code (only once all digits are in)
//   request      out  1        session active (level)
//   confirm      out  1        code submitted (level)
//   user         out  8        collected code, first digit in MSBs
//   digit_count  out  2        digits accepted this session, saturates
//   timed_out    out  1        one-cycle pulse on inactivity abort
// Configuration
//   ENTRY_TIMEOUT_EN  defined  : idle counter aborts COLLECT/READY after
//                                TIMEOUT_CYCLES clocks without an accepted key.
//                     undefined: no counter, sessions never time out,
//                                timed_out tied low, TIMEOUT_CYCLES unused.
// ============================================================================
module code_entry_unit #(
    parameter int DIGIT_W        = 4,
    parameter int NUM_DIGITS     = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_btn,
    input  logic               cancel_btn,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_code,
    input  logic               enter_btn,
    output logic               request,
    output logic               confirm,
    output logic [7:0]         user,
    output logic [1:0]         digit_count,
    output logic               timed_out
);

    localparam int c_USER_W = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_READY   = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_USER_W-1:0] r_user;
    logic [c_USER_W-1:0] w_user_nxt;
    logic [1:0]          r_digit_count;
    logic [1:0]          w_count_nxt;
    logic                r_request;
    logic                r_confirm;
    logic                r_timed_out;
    logic                w_timed_out_nxt;
    logic                w_key_accept;
    logic                w_timeout;
    logic                w_in_window;

    // The idle counter only matters while the user is typing or deciding.
    assign w_in_window = (r_state == S_COLLECT) || (r_state == S_READY);

`ifdef ENTRY_TIMEOUT_EN
    localparam int c_TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_TO_W-1:0] r_idle_cnt;

    assign w_timeout = w_in_window && (r_idle_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));

    // Cleared on every state change (covers entry into COLLECT/READY and the
    // exit to IDLE/HOLD), on every accepted key and outside the window.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idle_cnt <= '0;
        end else if (!w_in_window || w_key_accept || (w_state_nxt != r_state)) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    logic w_unused_timeout_cfg;

    assign w_timeout            = 1'b0;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_user        <= '0;
            r_digit_count <= '0;
            r_request     <= 1'b0;
            r_confirm     <= 1'b0;
            r_timed_out   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_user        <= w_user_nxt;
            r_digit_count <= w_count_nxt;
            r_request     <= (w_state_nxt != S_IDLE);
            r_confirm     <= (w_state_nxt == S_HOLD);
            r_timed_out   <= w_timed_out_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. Same-cycle priority: cancel > timeout > key > enter.
    // start is only looked at in IDLE, so request always drops for at least
    // one cycle between sessions.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_user_nxt      = r_user;
        w_count_nxt     = r_digit_count;
        w_timed_out_nxt = 1'b0;
        w_key_accept    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start_btn) begin
                    w_state_nxt = S_COLLECT;
                    w_user_nxt  = '0;
                    w_count_nxt = '0;
                end
            end

            S_COLLECT: begin
                if (cancel_btn) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end else if (w_timeout) begin
                    w_state_nxt     = S_IDLE;
                    w_count_nxt     = '0;
                    w_timed_out_nxt = 1'b1;
                end else if (key_valid) begin
                    // enter_btn in the same cycle is dropped here by design.
                    w_key_accept = 1'b1;
                    w_user_nxt   = {r_user[c_USER_W-DIGIT_W-1:0], key_code};
                    w_count_nxt  = r_digit_count + 2'd1;
                    if (r_digit_count == 2'(NUM_DIGITS - 1)) begin
                        w_state_nxt = S_READY;
                    end
                end
            end

            S_READY: begin
                if (cancel_btn) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end else if (w_timeout) begin
                    w_state_nxt     = S_IDLE;
                    w_count_nxt     = '0;
                    w_timed_out_nxt = 1'b1;
                end else if (enter_btn) begin
                    w_state_nxt = S_HOLD;
                end
            end

            S_HOLD: begin
                // confirm must stay stable for the controller: only cancel exits.
                if (cancel_btn) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    assign request     = r_request;
    assign confirm     = r_confirm;
    assign user        = r_user;
    assign digit_count = r_digit_count;
    assign timed_out   = r_timed_out;

endmodule
`default_nettype wire

// File: tb/tb_code_entry_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_code_entry_unit
// Description : Self-checking bench for code_entry_unit. Directed scenarios
//               followed by randomized button/key traffic, all compared every
//               cycle against a session-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_code_entry_unit;

    localparam int c_DIGIT_W    = 4;
    localparam int c_NUM_DIGITS = 2;
    localparam int c_TIMEOUT    = 16;
`ifdef ENTRY_TIMEOUT_EN
    localparam bit c_TO_EN = 1'b1;
`else
    localparam bit c_TO_EN = 1'b0;
`endif

    logic                 clock;
    logic                 reset;
    logic                 start_btn;
    logic                 cancel_btn;
    logic                 key_valid;
    logic [c_DIGIT_W-1:0] key_code;
    logic                 enter_btn;
    logic                 request;
    logic                 confirm;
    logic [7:0]           user;
    logic [1:0]           digit_count;
    logic                 timed_out;

    int checks = 0;
    int errors = 0;

    // Reference model: a session is either closed, open and collecting digits,
    // or submitted. The code is the digit list read as a base-16 number.
    bit m_active;
    bit m_submitted;
    int m_digits[$];
    int m_user;
    int m_idle;
    bit m_pulse;

    code_entry_unit #(
        .DIGIT_W        (c_DIGIT_W),
        .NUM_DIGITS     (c_NUM_DIGITS),
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start_btn   (start_btn),
        .cancel_btn  (cancel_btn),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .enter_btn   (enter_btn),
        .request     (request),
        .confirm     (confirm),
        .user        (user),
        .digit_count (digit_count),
        .timed_out   (timed_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active    = 1'b0;
        m_submitted = 1'b0;
        m_digits.delete();
        m_user      = 0;
        m_idle      = 0;
        m_pulse     = 1'b0;
    endtask

    task automatic model_close();
        m_active    = 1'b0;
        m_submitted = 1'b0;
        m_digits.delete();
    endtask

    task automatic model_step(input bit st, input bit ca, input bit kv,
                              input int kc, input bit en);
        m_pulse = 1'b0;
        if (!m_active) begin
            if (st) begin
                m_active = 1'b1;
                m_digits.delete();
                m_user   = 0;
                m_idle   = 0;
            end
        end else if (m_submitted) begin
            if (ca) model_close();
        end else begin
            if (ca) begin
                model_close();
            end else if (c_TO_EN && (m_idle == c_TIMEOUT - 1)) begin
                model_close();
                m_pulse = 1'b1;
            end else if (kv && (m_digits.size() < c_NUM_DIGITS)) begin
                m_digits.push_back(kc);
                m_user = (m_user * 16 + kc) % 256;
                m_idle = 0;
            end else if (en && (m_digits.size() == c_NUM_DIGITS)) begin
                m_submitted = 1'b1;
            end else begin
                m_idle++;
            end
        end
    endtask

    task automatic check_all();
        chk("request",     int'(request),     int'(m_active));
        chk("confirm",     int'(confirm),     int'(m_submitted));
        chk("user",        int'(user),        m_user);
        chk("digit_count", int'(digit_count), m_digits.size());
        chk("timed_out",   int'(timed_out),   int'(m_pulse));
    endtask

    task automatic cycle(input bit st, input bit ca, input bit kv,
                         input int kc, input bit en);
        start_btn  = st;
        cancel_btn = ca;
        key_valid  = kv;
        key_code   = 4'(kc);
        enter_btn  = en;
        @(posedge clock);
        model_step(st, ca, kv, kc, en);
        #1;
        check_all();
        start_btn  = 1'b0;
        cancel_btn = 1'b0;
        key_valid  = 1'b0;
        key_code   = '0;
        enter_btn  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
    endtask

    initial begin
        int pulses;
        reset      = 1'b1;
        start_btn  = 1'b0;
        cancel_btn = 1'b0;
        key_valid  = 1'b0;
        key_code   = '0;
        enter_btn  = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all();
        reset = 1'b0;
        idle_cycles(2);

        // Reset asserted mid-COLLECT clears outputs without a clock edge.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 4'h9, 0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clock);
        #1;
        check_all();
        reset = 1'b0;
        idle_cycles(2);

        // Basic session: 0x0, 0x5, enter; confirm held until cancel.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 4'h0, 0);
        cycle(0, 0, 1, 4'h5, 0);
        cycle(0, 0, 0, 0, 1);
        idle_cycles(3);
        chk("t2_user", int'(user), 8'h05);
        chk("t2_confirm_held", int'(confirm), 1);
        cycle(1, 0, 1, 4'hF, 1);
        cycle(0, 1, 0, 0, 0);
        chk("t2_request_after_cancel", int'(request), 0);
        idle_cycles(1);

        // Third key is ignored once the code is complete.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 4'h3, 0);
        cycle(0, 0, 1, 4'h7, 0);
        cycle(0, 0, 1, 4'h9, 0);
        cycle(0, 0, 0, 0, 1);
        chk("t3_user", int'(user), 8'h37);
        cycle(0, 1, 0, 0, 0);

        // Enter on an incomplete code is dropped; key+enter together drops enter.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 4'h5, 0);
        cycle(0, 0, 0, 0, 1);
        chk("t4_confirm_incomplete", int'(confirm), 0);
        cycle(0, 0, 1, 4'hA, 1);
        chk("t4_confirm_key_enter", int'(confirm), 0);
        cycle(0, 0, 0, 0, 1);
        chk("t4_user", int'(user), 8'h5A);
        cycle(0, 1, 0, 0, 0);

        // Inactivity: one key then silence.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 4'h1, 0);
        pulses = 0;
        for (int i = 0; i < 3 * c_TIMEOUT; i++) begin
            cycle(0, 0, 0, 0, 0);
            if (timed_out === 1'b1) pulses++;
        end
        chk("t5_pulses", pulses, c_TO_EN ? 1 : 0);
        chk("t5_request", int'(request), c_TO_EN ? 0 : 1);
        cycle(0, 1, 0, 0, 0);
        idle_cycles(1);

        // Key and cancel together: cancel wins, code retained.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 4'hC, 0);
        cycle(0, 1, 1, 4'h4, 0);
        chk("t6_digit_count", int'(digit_count), 0);
        chk("t6_user", int'(user), 8'h0C);
        idle_cycles(1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 2) == 0),
                  int'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 9) == 0) idle_cycles(int'($urandom_range(1, 20)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
